vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40; H_SYNC, default 128; H_BP, default 88; horizontal porch and sync widths in pixels.
REQ-003 Parameter V_ACTIVE, default 600; V_FP, default 1; V_SYNC, default 4; V_BP, default 23; vertical widths in lines.
REQ-004 Parameter SYNC_POL, default 1, active level of hsync/vsync (1 = active-high).
REQ-005 Parameter BG_COLOUR, default 12'h000, rgb value driven on the bus.
REQ-006 pclk  input  1  pixel clock; all state changes on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 en  input  1  count enable; low freezes all counters and outputs.
REQ-009 vga_bus_out  output  VGA_BUS_SIZE  standard VGA bus {hcount[10:0], vcount[10:0], hsync, vsync, rgb[11:0]}, the head of the drawing pipeline.
REQ-010 hblnk  output  1  horizontal blanking, aligned with vga_bus_out.
REQ-011 vblnk  output  1  vertical blanking, aligned with vga_bus_out.
REQ-012 frame_start  output  1  one-cycle pulse on the first pixel of each frame.
REQ-013 frame_cnt  output  16  completed-frame counter.

Function
REQ-014 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056 default); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628 default); both SHALL fit in 11 bits.
REQ-015 The horizontal counter SHALL increment by 1 per enabled cycle from 0 to H_TOTAL-1, then wrap to 0.
REQ-016 The vertical counter SHALL increment only in the cycle where the horizontal counter wraps, counting 0..V_TOTAL-1, then wrapping to 0.
REQ-017 All outputs SHALL be registered, with next-state decode, so every output matches the hcount/vcount it is presented with in the same cycle (zero skew across the bus).
REQ-018 hblnk SHALL be 1 iff hcount >= H_ACTIVE; vblnk SHALL be 1 iff vcount >= V_ACTIVE.
REQ-019 hsync SHALL be at its active level iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (840..967 default); otherwise inactive.
REQ-020 vsync SHALL be at its active level iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (601..604 default); otherwise inactive.
REQ-021 The bus rgb field SHALL be BG_COLOUR while both blanks are 0, and 12'h000 while either blank is 1.
REQ-022 frame_start SHALL be 1 for exactly one cycle when the outputs present hcount=0 and vcount=0 after a wrap from (H_TOTAL-1, V_TOTAL-1); it SHALL NOT pulse on the first cycle after reset release.
REQ-023 frame_cnt SHALL increment in the same cycle that frame_start is 1, and wrap from 16'hFFFF to 0.
REQ-024 While en=0, all counters and registered outputs SHALL hold their values, and frame_start SHALL be 0.
REQ-025 When en returns to 1, counting SHALL resume from the held position with no skipped or repeated count.

Reset
REQ-026 While rst=0, asynchronously: hcount=0, vcount=0, hblnk=0, vblnk=0, hsync and vsync inactive (=!SYNC_POL), rgb=0, frame_start=0, frame_cnt=0.
REQ-027 After rst rises, the first enabled edge SHALL advance hcount to 1. The display position (0,0) is treated as already presented during reset.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; no partial sync pulse may persist after rst falls.

Verification
REQ-029 Release reset with en=1 and run 1056 cycles -> hcount steps 0..1055 then reads 0; vcount steps 0->1 in the same cycle; hsync high exactly for hcount 840..967 (128 cycles).
REQ-030 Run a full frame (1056*628 cycles) -> vsync high for vcount 601..604; vblnk high for 600..627; frame_start pulses once at wrap to (0,0); frame_cnt=1.
REQ-031 Hold en=0 for 50 cycles at hcount=839 -> all outputs frozen; after en=1, the next cycle shows hcount=840 with hsync high.
REQ-032 Assert rst at hcount=900, vcount=602 -> outputs immediately show 0/0 with syncs inactive and frame_cnt=0; no frame_start on release.
REQ-033 SYNC_POL=0 build -> hsync/vsync low only in their sync windows, high during reset.
REQ-034 Preload frame_cnt=16'hFFFF via forced run or back-door -> next frame_start gives frame_cnt=0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, blanking
// and background colour, all decoded from the next position so the bus has zero skew.
module vga_timing_gen #(
  parameter int          H_ACTIVE  = 800,
  parameter int          H_FP      = 40,
  parameter int          H_SYNC    = 128,
  parameter int          H_BP      = 88,
  parameter int          V_ACTIVE  = 600,
  parameter int          V_FP      = 1,
  parameter int          V_SYNC    = 4,
  parameter int          V_BP      = 23,
  parameter bit          SYNC_POL  = 1'b1,
  parameter logic [11:0] BG_COLOUR = 12'h000,
  localparam int         VGA_BUS_SIZE = 36
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic                    en,
  output logic [VGA_BUS_SIZE-1:0] vga_bus_out,
  output logic                    hblnk,
  output logic                    vblnk,
  output logic                    frame_start,
  output logic [15:0]             frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [10:0] hcount_q, vcount_q;
  logic [10:0] hcount_nxt, vcount_nxt;
  logic        hsync_q, vsync_q, hblnk_q, vblnk_q, frame_start_q;
  logic        hsync_nxt, vsync_nxt, hblnk_nxt, vblnk_nxt, frame_start_nxt;
  logic [11:0] rgb_q, rgb_nxt;
  logic [15:0] frame_cnt_q;

  // Everything below is decoded from the position about to be presented, so each
  // registered output lines up with the hcount/vcount it is sent with.
  always_comb begin
    hcount_nxt = hcount_q + 11'd1;
    vcount_nxt = vcount_q;
    if (hcount_q == 11'(H_TOTAL - 1)) begin
      hcount_nxt = 11'd0;
      vcount_nxt = (vcount_q == 11'(V_TOTAL - 1)) ? 11'd0 : vcount_q + 11'd1;
    end
    hblnk_nxt       = (hcount_nxt >= 11'(H_ACTIVE));
    vblnk_nxt       = (vcount_nxt >= 11'(V_ACTIVE));
    hsync_nxt       = (hcount_nxt >= 11'(HS_START) && hcount_nxt < 11'(HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_nxt       = (vcount_nxt >= 11'(VS_START) && vcount_nxt < 11'(VS_END)) ? SYNC_POL : ~SYNC_POL;
    rgb_nxt         = (hblnk_nxt || vblnk_nxt) ? 12'h000 : BG_COLOUR;
    frame_start_nxt = (hcount_nxt == 11'd0) && (vcount_nxt == 11'd0);
  end

  // en low freezes the raster; only the frame_start pulse is forced back to 0.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      rgb_q         <= 12'h000;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else if (en) begin
      hcount_q      <= hcount_nxt;
      vcount_q      <= vcount_nxt;
      hblnk_q       <= hblnk_nxt;
      vblnk_q       <= vblnk_nxt;
      hsync_q       <= hsync_nxt;
      vsync_q       <= vsync_nxt;
      rgb_q         <= rgb_nxt;
      frame_start_q <= frame_start_nxt;
      if (frame_start_nxt) frame_cnt_q <= frame_cnt_q + 16'd1;
    end else begin
      frame_start_q <= 1'b0;
    end
  end

  assign vga_bus_out = {hcount_q, vcount_q, hsync_q, vsync_q, rgb_q};
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two builds (default-width lines with active-high sync, and a
// tiny raster with active-low sync) checked every cycle against a raster-position model.
module tb_vga_timing_gen;

  // Build A: default horizontal timing, short frame so whole frames fit in the run.
  localparam int A_HA = 800, A_HF = 40, A_HS = 128, A_HB = 88;
  localparam int A_VA = 6, A_VF = 1, A_VS = 2, A_VB = 3;
  localparam int A_HT = A_HA + A_HF + A_HS + A_HB;
  localparam int A_VT = A_VA + A_VF + A_VS + A_VB;
  localparam logic [11:0] A_BG = 12'h3F1;
  // Build B: tiny raster, active-low sync.
  localparam int B_HA = 4, B_HF = 2, B_HS = 3, B_HB = 1;
  localparam int B_VA = 3, B_VF = 1, B_VS = 2, B_VB = 2;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB;
  localparam int B_VT = B_VA + B_VF + B_VS + B_VB;
  localparam logic [11:0] B_BG = 12'hA5C;

  logic        pclk, rst, en;
  logic [35:0] bus_a, bus_b;
  logic        hblnk_a, vblnk_a, fs_a, hblnk_b, vblnk_b, fs_b;
  logic [15:0] fc_a, fc_b;

  int checks = 0;
  int errors = 0;
  bit running = 0;

  // model state: linear raster position, "still showing reset values", pulse, frame count
  int          pos_a, pos_b;
  bit          fresh_a, fresh_b, mfs_a, mfs_b;
  logic [15:0] mfc_a, mfc_b;

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .SYNC_POL(1'b1), .BG_COLOUR(A_BG)
  ) dut_a (
    .pclk(pclk), .rst(rst), .en(en), .vga_bus_out(bus_a),
    .hblnk(hblnk_a), .vblnk(vblnk_a), .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .SYNC_POL(1'b0), .BG_COLOUR(B_BG)
  ) dut_b (
    .pclk(pclk), .rst(rst), .en(en), .vga_bus_out(bus_b),
    .hblnk(hblnk_b), .vblnk(vblnk_b), .frame_start(fs_b), .frame_cnt(fc_b)
  );

  // clock / reset block
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog act=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // expected {hblnk, vblnk, bus} for a raster position, straight from the timing rules
  function automatic logic [37:0] expect_out(int pos, int ht, int ha, int hf, int hs,
                                             int va, int vf, int vs, bit pol,
                                             logic [11:0] bg, bit fresh);
    int h, v;
    logic hb, vb, hsy, vsy;
    logic [11:0] rgb;
    h   = pos % ht;
    v   = pos / ht;
    hb  = (h >= ha);
    vb  = (v >= va);
    hsy = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
    vsy = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
    rgb = (hb || vb) ? 12'h000 : bg;
    if (fresh) rgb = 12'h000;
    return {hb, vb, 11'(h), 11'(v), hsy, vsy, rgb};
  endfunction

  always @(posedge pclk or negedge rst) begin
    if (!rst) begin
      pos_a = 0; pos_b = 0; fresh_a = 1; fresh_b = 1;
      mfs_a = 0; mfs_b = 0; mfc_a = 16'd0; mfc_b = 16'd0;
    end else if (en) begin
      pos_a = (pos_a + 1) % (A_HT * A_VT);
      pos_b = (pos_b + 1) % (B_HT * B_VT);
      fresh_a = 0; fresh_b = 0;
      mfs_a = (pos_a == 0);
      mfs_b = (pos_b == 0);
      if (mfs_a) mfc_a = mfc_a + 16'd1;
      if (mfs_b) mfc_b = mfc_b + 16'd1;
    end else begin
      mfs_a = 0; mfs_b = 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 40) $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every cycle, both builds against the model
  always @(negedge pclk) begin
    if (running) begin
      chk("a_out", {hblnk_a, vblnk_a, bus_a},
          expect_out(pos_a, A_HT, A_HA, A_HF, A_HS, A_VA, A_VF, A_VS, 1'b1, A_BG, fresh_a));
      chk("a_frame", {fs_a, fc_a}, {mfs_a, mfc_a});
      chk("b_out", {hblnk_b, vblnk_b, bus_b},
          expect_out(pos_b, B_HT, B_HA, B_HF, B_HS, B_VA, B_VF, B_VS, 1'b0, B_BG, fresh_b));
      chk("b_frame", {fs_b, fc_b}, {mfs_b, mfc_b});
    end
  end

  // driver: n rising edges, then settle just past the last one
  task automatic edges(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    bit got;
    rst = 1'b0;
    en  = 1'b0;
    running = 1;
    edges(3);
    chk("rst_a_hcount", 64'(bus_a[35:25]), 64'd0);
    chk("rst_a_syncs", 64'(bus_a[13:12]), 64'b00);
    chk("rst_b_syncs", 64'(bus_b[13:12]), 64'b11);
    chk("rst_a_rgb", 64'(bus_a[11:0]), 64'h000);

    rst = 1'b1;
    en  = 1'b1;
    edges(1);
    chk("first_edge_hcount", 64'(bus_a[35:25]), 64'd1);
    chk("first_edge_no_fs", 64'({fs_a, fs_b}), 64'b00);
    edges(838);
    chk("pre_sync_hcount", 64'(bus_a[35:25]), 64'd839);
    chk("pre_sync_hsync", 64'(bus_a[13]), 64'd0);
    en = 1'b0;
    edges(50);
    chk("hold_hcount", 64'(bus_a[35:25]), 64'd839);
    chk("hold_hsync", 64'(bus_a[13]), 64'd0);
    en = 1'b1;
    edges(1);
    chk("resume_hcount", 64'(bus_a[35:25]), 64'd840);
    chk("resume_hsync", 64'(bus_a[13]), 64'd1);
    edges(216);
    chk("line_wrap_pos", 64'({bus_a[35:25], bus_a[24:14]}), 64'({11'd0, 11'd1}));
    edges(11615);
    chk("frame_end_pos", 64'({bus_a[35:25], bus_a[24:14], fs_a}), 64'({11'd1055, 11'd11, 1'b0}));
    edges(1);
    chk("frame_wrap", 64'({bus_a[35:25], bus_a[24:14], fs_a, fc_a}),
        64'({11'd0, 11'd0, 1'b1, 16'd1}));
    edges(1);
    chk("frame_pulse_once", 64'({fs_a, fc_a}), 64'({1'b0, 16'd1}));

    edges(9347);
    chk("mid_sync_pos", 64'({bus_a[35:25], bus_a[24:14]}), 64'({11'd900, 11'd8}));
    chk("mid_sync_active", 64'(bus_a[13:12]), 64'b11);
    rst = 1'b0;
    #1;
    chk("async_rst_out", 64'({bus_a[35:12], fs_a, fc_a}), 64'({11'd0, 11'd0, 2'b00, 1'b0, 16'd0}));
    chk("async_rst_b_syncs", 64'(bus_b[13:12]), 64'b11);
    edges(2);
    rst = 1'b1;
    edges(1);
    chk("post_rst_no_fs", 64'({fs_a, bus_a[35:25]}), 64'({1'b0, 11'd1}));

    // back-door preload of the frame counter, then watch it wrap
    force dut_b.frame_cnt_q = 16'hFFFF;
    mfc_b = 16'hFFFF;
    #1;
    release dut_b.frame_cnt_q;
    got = 0;
    for (int i = 0; i < 4 * B_HT * B_VT && !got; i++) begin
      edges(1);
      if (fs_b) got = 1;
    end
    chk("wrap_seen", 64'(got), 64'd1);
    chk("frame_cnt_wrap", 64'(fc_b), 64'd0);

    for (int i = 0; i < 40000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 4999) == 0) begin
        rst = 1'b0;
        edges($urandom_range(1, 3));
        rst = 1'b1;
      end
      edges(1);
    end

    running = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
